data_mem_bridge: RTL and testbench

- Sits between the multi-cycle CPU core's MEM stage and data memory. Memory is now a valid/ready handshake port with variable latency, not a fixed one-cycle port.
- Captures one load/store request from the core and holds it stable until memory accepts it.
- For loads, waits for and buffers the response word.
- Returns a one-cycle completion pulse so the core's MEM state can stall until the access finishes. Includes a watchdog against a hung memory.

---
 rtl/data_mem_bridge_pkg.sv | 19 +
 rtl/mem_watchdog.sv | 32 +++
 rtl/data_mem_bridge.sv | 136 +++++++++++++
 tb/tb_data_mem_bridge.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_bridge_pkg.sv
// Shared definitions for the MEM-stage data memory bridge: one-hot state
// encoding, address alignment and the default watchdog limit.
package data_mem_bridge_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_RESP = 4'b0100,
    S_DONE = 4'b1000
  } state_e;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam int          DEFAULT_TIMEOUT = 255;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Cycle watchdog for a memory handshake: counts enabled cycles since the last
// clear and flags the cycle in which the TIMEOUT-th enabled cycle is spent.
module mem_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_spent;

  // w_spent includes the current cycle, so expiry lands on the TIMEOUT-th cycle
  assign w_spent  = {1'b0, r_cnt} + 1'b1;
  assign o_expire = (TIMEOUT != 0) && i_en && (w_spent == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges the core's single-cycle MEM request onto a valid/ready data memory
// port with variable latency; pulses core_done when the access retires.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_wen,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wstrb,
  output logic        core_busy,
  output logic        core_done,
  output logic        core_err,
  output logic [31:0] core_rdata,
  output logic [31:0] Address,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] Write_data,
  output logic [3:0]  Write_strb,
  input  logic        Mem_Req_Ready,
  input  logic [31:0] Read_data,
  input  logic        Read_data_Valid,
  output logic        Read_data_Ready,
  output logic        err_sticky
);

  state_e      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic        r_wen, r_to, r_sticky;
  logic        w_clr, w_en, w_expire, w_timeout;

  assign w_en = (r_state == S_REQ) || (r_state == S_RESP);

  mem_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .o_expire (w_expire)
  );

  // A handshake in the expiry cycle takes priority over the abort.
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (core_req) begin
          w_next = S_REQ;
          w_clr  = 1'b1;
        end
      end
      S_REQ: begin
        if (Mem_Req_Ready) begin
          w_next = r_wen ? S_DONE : S_RESP;
          w_clr  = ~r_wen;
        end else if (w_expire) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_RESP: begin
        if (Read_data_Valid) begin
          w_next = S_DONE;
        end else if (w_expire) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_wen   <= 1'b0;
    end else if ((r_state == S_IDLE) && core_req) begin
      r_addr  <= core_addr;
      r_wdata <= core_wdata;
      r_wstrb <= core_wstrb;
      r_wen   <= core_wen;
    end
  end

  // Abort flag lives for one access; the sticky copy survives until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata  <= '0;
      r_to     <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      if ((r_state == S_RESP) && Read_data_Valid)
        r_rdata <= Read_data;
      if (r_state == S_IDLE)
        r_to <= 1'b0;
      else if (w_timeout)
        r_to <= 1'b1;
      if (w_timeout)
        r_sticky <= 1'b1;
    end
  end

  assign Address         = word_align(r_addr);
  assign MemWrite        = (r_state == S_REQ) &&  r_wen;
  assign MemRead         = (r_state == S_REQ) && !r_wen;
  assign Write_data      = r_wdata;
  assign Write_strb      = r_wstrb;
  assign Read_data_Ready = (r_state == S_RESP);
  assign core_busy       = (r_state != S_IDLE);
  assign core_done       = (r_state == S_DONE);
  assign core_err        = (r_state == S_DONE) && r_to;
  assign core_rdata      = r_rdata;
  assign err_sticky      = r_sticky;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge with a 4-cycle watchdog.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_wen;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_wstrb;
  logic        core_busy, core_done, core_err;
  logic [31:0] core_rdata;
  logic [31:0] Address, Write_data;
  logic        MemWrite, MemRead;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid, Read_data_Ready;
  logic        err_sticky;

  always #5 clk = ~clk;

  data_mem_bridge #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_wen(core_wen), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wstrb(core_wstrb),
    .core_busy(core_busy), .core_done(core_done), .core_err(core_err),
    .core_rdata(core_rdata),
    .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
    .Write_data(Write_data), .Write_strb(Write_strb),
    .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .err_sticky(err_sticky)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          req_wait;
    int          resp_wait;
    logic [31:0] rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        sticky;
    int          lat;
  } exp_t;

  vec_t        vecs[8];
  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic        m_sticky = 1'b0;
  logic [31:0] m_rdata  = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   rq, rs;
    bit   got;
    if (v.exp_err) m_sticky = 1'b1;
    if (!v.wen && !v.exp_err) m_rdata = v.rdata;
    e.err = v.exp_err; e.rdata = m_rdata; e.sticky = m_sticky; e.lat = v.exp_lat;
    sb.push_back(e);
    @(negedge clk);
    core_req = 1'b1; core_wen = v.wen; core_addr = v.addr;
    core_wdata = v.wdata; core_wstrb = v.wstrb;
    rq = 0; rs = 0; got = 1'b0;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      @(negedge clk);
      core_req = 1'b0;
      if (core_done) begin
        Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b0; got = 1'b1;
        e = sb.pop_front();
        chk("latency", cyc, e.lat);
        chk("core_err", {31'b0, core_err}, {31'b0, e.err});
        chk("core_rdata", core_rdata, e.rdata);
        chk("err_sticky", {31'b0, err_sticky}, {31'b0, e.sticky});
      end else if (MemRead || MemWrite) begin
        chk("Address", Address, v.addr & 32'hFFFF_FFFC);
        chk("MemWrite", {31'b0, MemWrite}, {31'b0, v.wen});
        chk("MemRead", {31'b0, MemRead}, {31'b0, ~v.wen});
        if (v.wen) begin
          chk("Write_data", Write_data, v.wdata);
          chk("Write_strb", {28'b0, Write_strb}, {28'b0, v.wstrb});
        end
        Mem_Req_Ready   = (rq >= v.req_wait);
        Read_data_Valid = 1'b1;          // must be ignored while in REQ
        Read_data       = 32'hDEAD_0000;
        rq++;
      end else if (Read_data_Ready) begin
        Mem_Req_Ready   = 1'b0;
        Read_data_Valid = (rs >= v.resp_wait);
        Read_data       = v.rdata;
        rs++;
      end else begin
        chk("busy_in_txn", {31'b0, core_busy}, 32'd1);
        Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b0;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL done_wait actual=no_core_done expected=core_done");
      void'(sb.pop_front());
    end
    Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'b0, core_busy}, 32'd0);
    chk("idle_done", {31'b0, core_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout actual=hung expected=finish");
    $fatal(1, "simulation hung");
  end

  initial begin
    vec_t v;
    //          wen   addr          wdata         wstrb  rqw rsw rdata         err  lat
    vecs[0] = '{1'b1, 32'h0000_1006, 32'hAABB_CCDD, 4'b1100, 0, 0, 32'h0,         1'b0, 1};
    vecs[1] = '{1'b0, 32'h0000_2002, 32'h0,         4'b0000, 3, 2, 32'h1234_5678, 1'b0, 7};
    vecs[2] = '{1'b1, 32'h0000_3000, 32'h1111_2222, 4'b0011, 3, 0, 32'h0,         1'b0, 4};
    vecs[3] = '{1'b0, 32'h0000_4004, 32'h0,         4'b0000, 0, 3, 32'hCAFE_F00D, 1'b0, 5};
    vecs[4] = '{1'b0, 32'h0000_0FFF, 32'h0,         4'b0000, 0, 0, 32'h0BAD_BEEF, 1'b0, 2};
    vecs[5] = '{1'b1, 32'h0000_5008, 32'h5555_AAAA, 4'b1111, 10, 0, 32'h0,        1'b1, 4};
    vecs[6] = '{1'b0, 32'h0000_600C, 32'h0,         4'b0000, 0, 10, 32'h7777_7777, 1'b1, 5};
    vecs[7] = '{1'b1, 32'h0000_7010, 32'h0102_0304, 4'b0001, 0, 0, 32'h0,         1'b0, 1};

    rst = 1'b0; core_req = 1'b0; core_wen = 1'b0; core_addr = '0;
    core_wdata = '0; core_wstrb = '0; Mem_Req_Ready = 1'b0;
    Read_data = '0; Read_data_Valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, core_busy}, 32'd0);
    chk("rst_done", {31'b0, core_done}, 32'd0);
    chk("rst_mem_valid", {30'b0, MemRead, MemWrite}, 32'd0);
    chk("rst_rready", {31'b0, Read_data_Ready}, 32'd0);
    chk("rst_sticky", {31'b0, err_sticky}, 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Back-to-back: core_req held high, second request only taken after DONE
    @(negedge clk);
    core_req = 1'b1; core_wen = 1'b1; core_addr = 32'h0000_0100;
    core_wdata = 32'hA0A0_A0A0; core_wstrb = 4'b1111; Mem_Req_Ready = 1'b1;
    @(negedge clk);
    chk("b2b_mw1", {31'b0, MemWrite}, 32'd1);
    chk("b2b_addr1", Address, 32'h0000_0100);
    core_addr = 32'h0000_0204; core_wdata = 32'hB0B0_B0B0;
    @(negedge clk);
    chk("b2b_done1", {31'b0, core_done}, 32'd1);
    chk("b2b_mw_done", {30'b0, MemRead, MemWrite}, 32'd0);
    @(negedge clk);
    chk("b2b_idle", {31'b0, core_busy}, 32'd0);
    chk("b2b_mw_idle", {30'b0, MemRead, MemWrite}, 32'd0);
    @(negedge clk);
    core_req = 1'b0;
    chk("b2b_mw2", {31'b0, MemWrite}, 32'd1);
    chk("b2b_addr2", Address, 32'h0000_0204);
    chk("b2b_wdata2", Write_data, 32'hB0B0_B0B0);
    @(negedge clk);
    chk("b2b_done2", {31'b0, core_done}, 32'd1);
    Mem_Req_Ready = 1'b0;
    @(negedge clk);
    chk("b2b_end_idle", {31'b0, core_busy}, 32'd0);

    // Reset while waiting for a load response
    core_req = 1'b1; core_wen = 1'b0; core_addr = 32'h0000_0800;
    @(negedge clk);
    core_req = 1'b0;
    chk("rl_mr", {31'b0, MemRead}, 32'd1);
    Mem_Req_Ready = 1'b1;
    @(negedge clk);
    Mem_Req_Ready = 1'b0;
    chk("rl_in_resp", {31'b0, Read_data_Ready}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rl_rready", {31'b0, Read_data_Ready}, 32'd0);
    chk("rl_mr_off", {31'b0, MemRead}, 32'd0);
    chk("rl_busy", {31'b0, core_busy}, 32'd0);
    chk("rl_sticky", {31'b0, err_sticky}, 32'd0);
    chk("rl_rdata", core_rdata, 32'd0);
    Read_data = 32'h9999_9999; Read_data_Valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rl_no_done", {31'b0, core_done}, 32'd0);
    end
    Read_data_Valid = 1'b0;
    rst = 1'b1;
    m_sticky = 1'b0; m_rdata = 32'h0;
    v = '{1'b0, 32'h0000_0804, 32'h0, 4'b0000, 1, 1, 32'h4242_4242, 1'b0, 4};
    run_txn(v);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
